// File: rtl/d7s_scan_if.sv
// Display bus of the scanned seven-segment driver: application-side value/control
// inputs and the board-facing segment/anode outputs.
interface d7s_scan_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   digit_en;
    logic [DIGITS-1:0]   dp;
    logic                blank_lz;
    logic [3:0]          bright;
    logic [6:0]          seg;
    logic                dp_o;
    logic [DIGITS-1:0]   an;
    logic                frame_start;

    modport master (
        output value, digit_en, dp, blank_lz, bright,
        input  seg, dp_o, an, frame_start
    );

    modport slave (
        input  value, digit_en, dp, blank_lz, bright,
        output seg, dp_o, an, frame_start
    );
endinterface

// File: rtl/d7s_scan.sv
// Time-multiplexed N-digit hex seven-segment driver with per-frame input snapshot,
// dead-time ghost suppression, PWM brightness and leading-zero blanking.
module d7s_scan #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int DEAD           = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    d7s_scan_if.slave  bus
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_DEAD = CNT_W'(DEAD);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1'b1);
    localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF   = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1'b1);

    // Hex nibble to active-high {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h27;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            4'hF:    pat = 7'h71;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    logic [CNT_W-1:0]    cnt_r;
    logic [IDX_W-1:0]    idx_r;
    logic [3:0]          pwm_r;
    logic [4*DIGITS-1:0] sh_val_r;
    logic [DIGITS-1:0]   sh_en_r;
    logic [DIGITS-1:0]   sh_dp_r;
    logic                sh_blz_r;
    logic                frame_start_r;
    logic [6:0]          seg_r;
    logic                dp_r;
    logic [DIGITS-1:0]   an_r;

    logic                wrap_s;
    logic                snap_s;
    logic                lz_run_s;
    logic [DIGITS-1:0]   lit_s;
    logic [3:0]          nib_s;
    logic                lit_cur_s;
    logic                duty_s;
    logic                settled_s;
    logic [6:0]          seg_next_s;
    logic                dp_next_s;
    logic [DIGITS-1:0]   an_next_s;

    assign wrap_s = (cnt_r == CNT_LAST);
    assign snap_s = wrap_s && (idx_r == IDX_LAST);

    // Slot counter, digit index and free-running PWM phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
            pwm_r <= 4'h0;
        end else begin
            pwm_r <= pwm_r + 4'h1;
            if (wrap_s) begin
                cnt_r <= {CNT_W{1'b0}};
                if (idx_r == IDX_LAST) begin
                    idx_r <= {IDX_W{1'b0}};
                end else begin
                    idx_r <= idx_r + IDX_ONE;
                end
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    // Frame snapshot of the application inputs, taken on the last cycle of the last slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_val_r      <= {(4*DIGITS){1'b0}};
            sh_en_r       <= {DIGITS{1'b0}};
            sh_dp_r       <= {DIGITS{1'b0}};
            sh_blz_r      <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= snap_s;
            if (snap_s) begin
                sh_val_r <= bus.value;
                sh_en_r  <= bus.digit_en;
                sh_dp_r  <= bus.dp;
                sh_blz_r <= bus.blank_lz;
            end
        end
    end

    // Per-digit visibility: zero-run scanned from the most significant digit down
    always_comb begin
        lz_run_s = 1'b1;
        lit_s    = {DIGITS{1'b0}};
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lz_run_s = lz_run_s && (sh_val_r[4*k +: 4] == 4'h0);
            if ((k != 0) && sh_blz_r && lz_run_s) begin
                lit_s[k] = 1'b0;
            end else begin
                lit_s[k] = sh_en_r[k];
            end
        end
    end

    // Next output values; the anode is only released once seg/dp_o already hold the
    // current digit, so new segments are never presented on a selected anode
    always_comb begin
        nib_s      = sh_val_r[{idx_r, 2'b00} +: 4];
        lit_cur_s  = lit_s[idx_r];
        duty_s     = (bus.bright == 4'hF) || (pwm_r < bus.bright);
        if (lit_cur_s) begin
            seg_next_s = SEG_OFF ^ hex_to_seg(nib_s);
        end else begin
            seg_next_s = SEG_OFF;
        end
        if (sh_dp_r[idx_r] && sh_en_r[idx_r]) begin
            dp_next_s = ~DP_OFF;
        end else begin
            dp_next_s = DP_OFF;
        end
        settled_s = (seg_r == seg_next_s) && (dp_r == dp_next_s);
        if ((cnt_r >= CNT_DEAD) && lit_cur_s && duty_s && settled_s) begin
            an_next_s = AN_OFF ^ (AN_ONE << idx_r);
        end else begin
            an_next_s = AN_OFF;
        end
    end

    // Registered pin drivers, all unlit/deselected while in reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r <= SEG_OFF;
            dp_r  <= DP_OFF;
            an_r  <= AN_OFF;
        end else begin
            seg_r <= seg_next_s;
            dp_r  <= dp_next_s;
            an_r  <= an_next_s;
        end
    end

    assign bus.seg         = seg_r;
    assign bus.dp_o        = dp_r;
    assign bus.an          = an_r;
    assign bus.frame_start = frame_start_r;

endmodule
